// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the sequential multiply/divide unit.
// twos_neg works on NEG_W bits; callers size-cast in and out, so WIDTH is limited to NEG_W/2.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int NEG_W = 128;

    function automatic logic [NEG_W-1:0] twos_neg(input logic [NEG_W-1:0] v);
        return ~v + NEG_W'(1);
    endfunction

endpackage

// File: rtl/mdu_iter_counter.sv
// Iteration counter for the multiply/divide unit: sync clear, enable, flag at WIDTH.
module mdu_iter_counter #(
    parameter int WIDTH = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == CNT_W'(WIDTH));

endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed/unsigned multiply (shift-add) and divide (restoring) unit.
// One iteration per clock; results and RDY appear WIDTH+1 cycles after the start edge.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_SIGNED,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_result_hi,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int W2 = 2 * WIDTH;

    state_t           state, state_nxt;
    logic             op_q, signed_q, neg_res_q, neg_rem_q, b_zero_q;
    logic [WIDTH-1:0] opnd_q, rem_q;
    logic [W2-1:0]    acc_q;

    logic             start, terminal, iterate, finish;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quo, rem;
    logic             mul_exc, div_exc;

    mdu_iter_counter #(.WIDTH(WIDTH)) u_iter_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (start),
        .enable   (iterate),
        .terminal (terminal)
    );

    // A start in any state wins: it aborts a running operation or chains after DONE.
    assign start          = ctrl_MULT | ctrl_DIV;
    assign busy           = (state == MUL) || (state == DIV);
    assign data_resultRDY = (state == DONE);
    assign iterate        = busy && !terminal;
    assign finish         = busy && terminal && !start;

    always_comb begin
        // NOTE: default first so no path through this block leaves state_nxt unassigned (no latch).
        state_nxt = state;
        if (ctrl_MULT) begin
            state_nxt = MUL;
        end else if (ctrl_DIV) begin
            state_nxt = DIV;
        end else begin
            case (state)
                MUL, DIV: if (terminal) state_nxt = DONE;
                DONE:     state_nxt = IDLE;
                default:  ;
            endcase
        end
    end

    always_comb begin
        a_neg = ctrl_SIGNED & data_operandA[WIDTH-1];
        b_neg = ctrl_SIGNED & data_operandB[WIDTH-1];
        a_mag = a_neg ? WIDTH'(twos_neg(NEG_W'(data_operandA))) : data_operandA;
        b_mag = b_neg ? WIDTH'(twos_neg(NEG_W'(data_operandB))) : data_operandB;

        mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{acc_q[0]}}};
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};

        prod = neg_res_q ? W2'(twos_neg(NEG_W'(acc_q))) : acc_q;
        quo  = neg_res_q ? WIDTH'(twos_neg(NEG_W'(acc_q[WIDTH-1:0]))) : acc_q[WIDTH-1:0];
        rem  = neg_rem_q ? WIDTH'(twos_neg(NEG_W'(rem_q))) : rem_q;

        mul_exc = signed_q ? (prod[W2-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                           : (prod[W2-1:WIDTH] != '0);
        // Only MIN / -1 yields a positive quotient magnitude of 2^(WIDTH-1).
        div_exc = signed_q & ~neg_res_q & acc_q[WIDTH-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: datapath registers are reset too, so outputs read 0 and no X reaches the pipeline.
            state          <= IDLE;
            op_q           <= OP_MUL;
            signed_q       <= 1'b0;
            neg_res_q      <= 1'b0;
            neg_rem_q      <= 1'b0;
            b_zero_q       <= 1'b0;
            opnd_q         <= '0;
            rem_q          <= '0;
            acc_q          <= '0;
            data_result    <= '0;
            data_result_hi <= '0;
            data_exception <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                op_q      <= ctrl_MULT ? OP_MUL : OP_DIV;
                signed_q  <= ctrl_SIGNED;
                neg_res_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                b_zero_q  <= (data_operandB == '0);
                opnd_q    <= ctrl_MULT ? a_mag : b_mag;
                acc_q     <= {{WIDTH{1'b0}}, (ctrl_MULT ? b_mag : a_mag)};
                rem_q     <= '0;
            end else if (iterate) begin
                if (op_q == OP_MUL) begin
                    acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                end else if (!div_diff[WIDTH]) begin
                    rem_q              <= div_diff[WIDTH-1:0];
                    acc_q[WIDTH-1:0]   <= {acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_q              <= div_shift[WIDTH-1:0];
                    acc_q[WIDTH-1:0]   <= {acc_q[WIDTH-2:0], 1'b0};
                end
            end else if (finish) begin
                if (op_q == OP_MUL) begin
                    data_result    <= prod[WIDTH-1:0];
                    data_result_hi <= prod[W2-1:WIDTH];
                    data_exception <= mul_exc;
                end else if (b_zero_q) begin
                    data_result    <= '0;
                    data_result_hi <= '0;
                    data_exception <= 1'b1;
                end else begin
                    data_result    <= quo;
                    data_result_hi <= rem;
                    data_exception <= div_exc;
                end
            end
        end
    end

endmodule
